bandit_btn_pulse: RTL and testbench



---
 rtl/bandit_btn_pulse.sv | 118 +++++++++++
 tb/tb_bandit_btn_pulse.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bandit_btn_pulse.sv
// Cabinet button conditioner: 2-FF synchronisers and debounce FSMs for START and COIN,
// with one-cycle press pulses and COIN-first arbitration when both are accepted together.
module bandit_btn_pulse #(
   parameter int unsigned DB_CYCLES = 20,
   parameter int unsigned CNT_W     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic start_btn,
   input  logic coin_btn,
   output logic start_p,
   output logic coin_p,
   output logic start_lvl,
   output logic coin_lvl
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   // Channel index 0 is START, 1 is COIN.
   logic [1:0]       s1_q;
   logic [1:0]       s2_q;
   state_t           st_q  [2];
   state_t           st_d  [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       ev;
   logic [1:0]       lvl_d;
   logic             start_pend_q;

   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         ev[i]    = 1'b0;
         case (st_q[i])
            IDLE: begin
               if (s2_q[i]) begin
                  st_d[i]  = PRESS_WAIT;
                  cnt_d[i] = CNT_W'(1);
               end else begin
                  cnt_d[i] = '0;
               end
            end
            PRESS_WAIT: begin
               if (!s2_q[i]) begin
                  st_d[i]  = IDLE;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  st_d[i]  = HELD;
                  cnt_d[i] = '0;
                  ev[i]    = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            HELD: begin
               if (!s2_q[i]) begin
                  st_d[i]  = REL_WAIT;
                  cnt_d[i] = CNT_W'(1);
               end
            end
            REL_WAIT: begin
               if (s2_q[i]) begin
                  st_d[i]  = HELD;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  st_d[i]  = IDLE;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               st_d[i]  = IDLE;
               cnt_d[i] = '0;
            end
         endcase
         lvl_d[i] = (st_d[i] == HELD) || (st_d[i] == REL_WAIT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q         <= '0;
         s2_q         <= '0;
         start_pend_q <= 1'b0;
         start_p      <= 1'b0;
         coin_p       <= 1'b0;
         start_lvl    <= 1'b0;
         coin_lvl     <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q <= {coin_btn, start_btn};
         s2_q <= s1_q;
         for (int unsigned i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         // A START accept coinciding with a COIN accept is deferred one cycle.
         coin_p       <= ev[1];
         start_p      <= start_pend_q | (ev[0] & ~ev[1]);
         start_pend_q <= ev[0] & ev[1];
         start_lvl    <= lvl_d[0];
         coin_lvl     <= lvl_d[1];
      end
   end

endmodule

// File: tb/tb_bandit_btn_pulse.sv
// Bench for bandit_btn_pulse: run-length debounce reference model feeds an expected-pulse
// queue; a negedge monitor matches observed pulses and levels against it.
module tb_bandit_btn_pulse;

   localparam int unsigned DB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_btn = 1'b0;
   logic coin_btn = 1'b0;
   logic start_p, coin_p, start_lvl, coin_lvl;

   bandit_btn_pulse #(.DB_CYCLES(DB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_btn (start_btn),
      .coin_btn  (coin_btn),
      .start_p   (start_p),
      .coin_p    (coin_p),
      .start_lvl (start_lvl),
      .coin_lvl  (coin_lvl)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit is_coin;
   } pulse_t;

   pulse_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference: debounced level flips once the delayed input has differed from it
   // for DB consecutive samples; a 0->1 flip is an accepted press.
   logic [1:0] h1 = '0, h2 = '0, lvl_m = '0;
   int run_m [2] = '{0, 0};

   int start_cnt = 0, coin_cnt = 0;
   int last_start = -1, last_coin = -1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      h1 = '0;
      h2 = '0;
      lvl_m = '0;
      run_m[0] = 0;
      run_m[1] = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit [1:0] acc;
      acc = '0;
      cyc++;
      for (int ch = 0; ch < 2; ch++) begin
         if (h2[ch] != lvl_m[ch]) begin
            run_m[ch]++;
            if (run_m[ch] == DB) begin
               lvl_m[ch] = h2[ch];
               run_m[ch] = 0;
               acc[ch] = h2[ch];
            end
         end else begin
            run_m[ch] = 0;
         end
      end
      h2 = h1;
      h1 = {coin_btn, start_btn};
      if (acc[1]) exp_q.push_back('{cyc: cyc, is_coin: 1'b1});
      if (acc[0]) exp_q.push_back('{cyc: (acc[1] ? cyc + 1 : cyc), is_coin: 1'b0});
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   task automatic match_pulse(input bit is_coin);
      int idx;
      idx = -1;
      foreach (exp_q[k]) if (idx < 0 && exp_q[k].cyc == cyc && exp_q[k].is_coin == is_coin) idx = k;
      chk(is_coin ? "coin_p_expected" : "start_p_expected", (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) exp_q.delete(idx);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {start_p, coin_p, start_lvl, coin_lvl}, 0);
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk(exp_q[0].is_coin ? "coin_p_missing" : "start_p_missing", exp_q[0].cyc, -1);
            void'(exp_q.pop_front());
         end
         chk("start_lvl", start_lvl, lvl_m[0]);
         chk("coin_lvl", coin_lvl, lvl_m[1]);
         chk("pulse_exclusive", start_p & coin_p, 0);
         if (coin_p) begin
            match_pulse(1'b1);
            coin_cnt++;
            last_coin = cyc;
         end
         if (start_p) begin
            match_pulse(1'b0);
            start_cnt++;
            last_start = cyc;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   initial begin
      int c, s, k;
      int rem [2];
      start_btn = 1'b1;
      coin_btn  = 1'b1;
      step(5);

      // Release reset with both held: coin first, start next cycle.
      rst = 1'b0;
      c = cyc;
      step(12);
      chk("rst_rel_coin_cnt", coin_cnt, 1);
      chk("rst_rel_start_cnt", start_cnt, 1);
      chk("rst_rel_coin_cyc", last_coin, c + 6);
      chk("rst_rel_start_cyc", last_start, c + 7);
      start_btn = 1'b0;
      coin_btn  = 1'b0;
      step(12);

      // Clean START press.
      s = start_cnt;
      k = coin_cnt;
      c = cyc;
      start_btn = 1'b1;
      step(20);
      chk("clean_start_cnt", start_cnt, s + 1);
      chk("clean_start_cyc", last_start, c + 6);
      chk("clean_coin_quiet", coin_cnt, k);
      start_btn = 1'b0;
      step(12);

      // Bouncy COIN press: 1,0,1,1,0 then stable 1.
      k = coin_cnt;
      coin_btn = 1'b1; step(1);
      coin_btn = 1'b0; step(1);
      coin_btn = 1'b1; step(2);
      coin_btn = 1'b0; step(1);
      c = cyc;
      coin_btn = 1'b1;
      step(20);
      chk("bounce_coin_cnt", coin_cnt, k + 1);
      chk("bounce_coin_cyc", last_coin, c + 6);
      coin_btn = 1'b0;
      step(12);

      // Short START glitch.
      s = start_cnt;
      start_btn = 1'b1; step(3);
      start_btn = 1'b0; step(12);
      chk("glitch_start_cnt", start_cnt, s);

      // Release bounce while held.
      s = start_cnt;
      start_btn = 1'b1; step(12);
      start_btn = 1'b0; step(2);
      start_btn = 1'b1; step(10);
      chk("relbounce_lvl_held", start_lvl, 1);
      c = cyc;
      start_btn = 1'b0;
      step(5);
      chk("relbounce_lvl_before", start_lvl, 1);
      step(1);
      chk("relbounce_lvl_after", start_lvl, 0);
      chk("relbounce_start_cnt", start_cnt, s + 1);
      step(8);

      // Simultaneous presses.
      c = cyc;
      start_btn = 1'b1;
      coin_btn  = 1'b1;
      step(15);
      chk("simul_coin_cyc", last_coin, c + 6);
      chk("simul_start_cyc", last_start, c + 7);
      start_btn = 1'b0;
      coin_btn  = 1'b0;
      step(12);

      // Reset asserted while a pulse is high.
      coin_btn = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (coin_p) break;
      end
      chk("midrst_pulse_seen", (k < 20) ? 1 : 0, 1);
      rst = 1'b1;
      coin_btn = 1'b0;
      #1;
      chk("midrst_outputs", {start_p, coin_p, start_lvl, coin_lvl}, 0);
      step(3);
      rst = 1'b0;
      step(12);

      // Random button activity with varied run lengths.
      rem[0] = 1;
      rem[1] = 1;
      for (int n = 0; n < 1500; n++) begin
         for (int ch = 0; ch < 2; ch++) begin
            rem[ch]--;
            if (rem[ch] == 0) begin
               if (ch == 0) start_btn = ~start_btn;
               else coin_btn = ~coin_btn;
               rem[ch] = $urandom_range(1, 12);
            end
         end
         step(1);
      end
      start_btn = 1'b0;
      coin_btn  = 1'b0;
      step(20);
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
